regfile_port_arbiter: RTL

//  Shares the single regfile port set (two read ports, one write port) between two

---
 rtl/regfile_port_arbiter_if.sv | 27 ++
 rtl/regfile_port_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Client-side request/response bundle for one requester of the shared regfile port set.
// The client drives the request fields; the arbiter returns grant and read data.
interface regfile_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  modport master (
    output req, we, ra1, ra2, wa, wd,
    input  gnt, rvalid, rd1, rd2
  );

  modport slave (
    input  req, we, ra1, ra2, wa, wd,
    output gnt, rvalid, rd1, rd2
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one regfile port set (2 read, 1 write) between clients A and B.
// Grant and strobes are combinational; read data returns to the granted client one cycle later.
module regfile_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_port_arbiter_if.slave   a,
  regfile_port_arbiter_if.slave   b,
  output logic [AW-1:0]           rf_r1,
  output logic [AW-1:0]           rf_r2,
  output logic [AW-1:0]           rf_w,
  output logic [DW-1:0]           rf_data,
  output logic                    rf_cr1,
  output logic                    rf_cr2,
  output logic                    rf_cw,
  input  logic [DW-1:0]           rf_d1,
  input  logic [DW-1:0]           rf_d2
);

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  client_e       last_gnt;
  client_e       tag_client;
  logic          tag_valid;
  logic [DW-1:0] a_hold1, a_hold2, b_hold1, b_hold2;

  logic          gnt_a, gnt_b, any_gnt, sel_we;
  logic [AW-1:0] sel_ra1, sel_ra2, sel_wa;
  logic [DW-1:0] sel_wd;
  logic          rvalid_a, rvalid_b;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    sel_we  = 1'b0;
    sel_ra1 = '0;
    sel_ra2 = '0;
    sel_wa  = '0;
    sel_wd  = '0;
    if (!rst) begin
      gnt_a = a.req && (!b.req || last_gnt == CLIENT_B);
      gnt_b = b.req && (!a.req || last_gnt == CLIENT_A);
    end
    if (gnt_a) begin
      sel_we  = a.we;
      sel_ra1 = a.ra1;
      sel_ra2 = a.ra2;
      sel_wa  = a.wa;
      sel_wd  = a.wd;
    end else if (gnt_b) begin
      sel_we  = b.we;
      sel_ra1 = b.ra1;
      sel_ra2 = b.ra2;
      sel_wa  = b.wa;
      sel_wd  = b.wd;
    end
  end

  assign any_gnt = gnt_a || gnt_b;
  assign rf_cw   = any_gnt && sel_we;
  assign rf_cr1  = any_gnt && !sel_we;
  assign rf_cr2  = any_gnt && !sel_we;
  assign rf_w    = rf_cw  ? sel_wa  : '0;
  assign rf_data = rf_cw  ? sel_wd  : '0;
  assign rf_r1   = rf_cr1 ? sel_ra1 : '0;
  assign rf_r2   = rf_cr2 ? sel_ra2 : '0;

  // Gating with rst drops an in-flight response the moment reset arrives.
  assign rvalid_a = tag_valid && !rst && (tag_client == CLIENT_A);
  assign rvalid_b = tag_valid && !rst && (tag_client == CLIENT_B);

  assign a.gnt    = gnt_a;
  assign b.gnt    = gnt_b;
  assign a.rvalid = rvalid_a;
  assign b.rvalid = rvalid_b;
  assign a.rd1    = rvalid_a ? rf_d1 : a_hold1;
  assign a.rd2    = rvalid_a ? rf_d2 : a_hold2;
  assign b.rd1    = rvalid_b ? rf_d1 : b_hold1;
  assign b.rd2    = rvalid_b ? rf_d2 : b_hold2;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= CLIENT_B;
      tag_valid  <= 1'b0;
      tag_client <= CLIENT_A;
      a_hold1    <= '0;
      a_hold2    <= '0;
      b_hold1    <= '0;
      b_hold2    <= '0;
    end else begin
      if (any_gnt) last_gnt <= gnt_b ? CLIENT_B : CLIENT_A;
      tag_valid  <= rf_cr1;
      tag_client <= gnt_b ? CLIENT_B : CLIENT_A;
      if (rvalid_a) begin
        a_hold1 <= rf_d1;
        a_hold2 <= rf_d2;
      end
      if (rvalid_b) begin
        b_hold1 <= rf_d1;
        b_hold2 <= rf_d2;
      end
    end
  end

endmodule
